// File: rtl/dmem_rr_arbiter_if.sv
// Core-array / data-memory bundle for dmem_rr_arbiter.
// The arbiter connects through the slave modport; the core array and memory side use master.
interface dmem_rr_arbiter_if #(
    parameter int N_CORES    = 4,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
);
    logic [N_CORES-1:0]            req;
    logic [N_CORES-1:0]            reqWrEn;
    logic [N_CORES*ADDR_WIDTH-1:0] reqAddr;
    logic [N_CORES*DATA_WIDTH-1:0] reqData;
    logic [N_CORES-1:0]            gnt;
    logic [N_CORES-1:0]            rdValid;
    logic [DATA_WIDTH-1:0]         rdData;
    logic                          memWrEn;
    logic [ADDR_WIDTH-1:0]         memAddr;
    logic [DATA_WIDTH-1:0]         memDataIn;
    logic [DATA_WIDTH-1:0]         memDataOut;
    logic                          busy;

    modport slave (
        input  req, reqWrEn, reqAddr, reqData, memDataOut,
        output gnt, rdValid, rdData, memWrEn, memAddr, memDataIn, busy
    );

    modport master (
        output req, reqWrEn, reqAddr, reqData, memDataOut,
        input  gnt, rdValid, rdData, memWrEn, memAddr, memDataIn, busy
    );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among N_CORES cores.
// Optional saturating conflict counter enabled by macro DMEM_ARB_CONFLICT_CNT_EN.
module dmem_rr_arbiter #(
    parameter int N_CORES    = 4,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
) (
    input  logic clk,
    input  logic rstN,
    dmem_rr_arbiter_if.slave bus
`ifdef DMEM_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0] conflictCnt
`endif
);
    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [N_CORES-1:0]    gnt_r;
    logic [N_CORES-1:0]    rd_valid_r;
    logic [PTR_W-1:0]      ptr_r;
    logic                  mem_wr_en_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_data_in_r;

    logic [N_CORES-1:0]    elig_s;
    logic [N_CORES-1:0]    win_oh_s;
    logic [PTR_W-1:0]      win_idx_s;
    logic [PTR_W-1:0]      ptr_nxt_s;
    logic                  win_vld_s;

    // A core whose grant is currently visible is masked so it cannot win twice.
    assign elig_s = bus.req & ~gnt_r;

    // Rotating-priority search from the pointer, wrapping to core 0.
    always_comb begin
        int         sum_v;
        logic [PTR_W-1:0] idx_v;
        win_vld_s = 1'b0;
        win_idx_s = '0;
        sum_v     = 0;
        idx_v     = '0;
        for (int k = 0; k < N_CORES; k++) begin
            sum_v = int'(ptr_r) + k;
            idx_v = (sum_v >= N_CORES) ? PTR_W'(sum_v - N_CORES) : PTR_W'(sum_v);
            if (!win_vld_s && elig_s[idx_v]) begin
                win_vld_s = 1'b1;
                win_idx_s = idx_v;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Winner decode and next pointer value.
    always_comb begin
        win_oh_s  = '0;
        ptr_nxt_s = ptr_r;
        if (win_vld_s) begin
            win_oh_s[win_idx_s] = 1'b1;
            ptr_nxt_s = (win_idx_s == PTR_W'(N_CORES - 1)) ? '0 : win_idx_s + PTR_W'(1);
        end else begin
            win_oh_s  = '0;
            ptr_nxt_s = ptr_r;
        end
    end

    // Grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            gnt_r <= '0;
            ptr_r <= '0;
        end else begin
            gnt_r <= win_oh_s;
            ptr_r <= ptr_nxt_s;
        end
    end

    // Registered memory request stage; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            mem_wr_en_r   <= 1'b0;
            mem_addr_r    <= '0;
            mem_data_in_r <= '0;
        end else if (win_vld_s) begin
            mem_wr_en_r   <= bus.reqWrEn[win_idx_s];
            mem_addr_r    <= bus.reqAddr[int'(win_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_data_in_r <= bus.reqData[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            mem_wr_en_r   <= 1'b0;
            mem_addr_r    <= mem_addr_r;
            mem_data_in_r <= mem_data_in_r;
        end
    end

    // Read return: the issuing core gets its valid one cycle after its grant.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rd_valid_r <= '0;
        end else begin
            rd_valid_r <= mem_wr_en_r ? '0 : gnt_r;
        end
    end

`ifdef DMEM_ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_r;
    logic        multi_elig_s;

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign multi_elig_s = |(elig_s & (elig_s - {{(N_CORES-1){1'b0}}, 1'b1}));

    // Saturating count of cycles with competing eligible cores.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            conflict_cnt_r <= 16'h0000;
        end else if (multi_elig_s && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'd1;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign conflictCnt = conflict_cnt_r;
`endif

    assign bus.gnt       = gnt_r;
    assign bus.rdValid   = rd_valid_r;
    assign bus.rdData    = bus.memDataOut;
    assign bus.memWrEn   = mem_wr_en_r;
    assign bus.memAddr   = mem_addr_r;
    assign bus.memDataIn = mem_data_in_r;
    assign bus.busy      = (|gnt_r) | (|rd_valid_r);
endmodule
